// File: rtl/tetris_sound_sched.sv
// Single-channel Tetris sound scheduler: background note loop plus four prioritised effects.
// Build option: TETRIS_SFX_PREEMPT_EN lets a higher-priority pending effect abort the one playing.
module tetris_sound_sched #(
  parameter int unsigned SFX_TICKS  = 10000000,
  parameter int unsigned NOTE_TICKS = 25000000,
  parameter int unsigned GAP_TICKS  = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sound_en,
  input  logic [3:0]  req,
  output logic [31:0] period,
  output logic [31:0] width,
  output logic        pwm_en,
  output logic        busy,
  output logic [1:0]  active_id,
  output logic [7:0]  drop_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SFX,
    ST_GAP
  } state_t;

  localparam logic [31:0] SFX_LEN   = 32'(SFX_TICKS);
  localparam logic [31:0] GO_LEN    = 32'(2 * SFX_TICKS);
  localparam logic [31:0] GAP_LEN   = 32'(GAP_TICKS);
  localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);

  function automatic logic [31:0] sfx_period(input logic [1:0] id);
    case (id)
      2'd0:    return 32'd454545;
      2'd1:    return 32'd113636;
      2'd2:    return 32'd75757;
      default: return 32'd606060;
    endcase
  endfunction

  function automatic logic [31:0] note_period(input logic [1:0] idx);
    case (idx)
      2'd0:    return 32'd151745;
      2'd1:    return 32'd202479;
      2'd2:    return 32'd191113;
      default: return 32'd170262;
    endcase
  endfunction

  state_t      state, state_n;
  logic [31:0] tmr, tmr_n;
  logic [1:0]  cur_id, cur_id_n;
  logic [3:0]  prev_req, pend, req_edge, grant;
  logic [31:0] note_timer;
  logic [1:0]  note_idx;
  logic        hi_valid, preempt, do_grant;
  logic [1:0]  hi_id;

  assign req_edge = req & ~prev_req;

  always_comb begin
    hi_valid = |pend;
    hi_id    = 2'd0;
    if (pend[3])      hi_id = 2'd3;
    else if (pend[2]) hi_id = 2'd2;
    else if (pend[1]) hi_id = 2'd1;
  end

`ifdef TETRIS_SFX_PREEMPT_EN
  assign preempt = hi_valid && (hi_id > cur_id);
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    tmr_n    = tmr;
    cur_id_n = cur_id;
    do_grant = 1'b0;
    grant    = '0;
    if (!sound_en) begin
      state_n = ST_IDLE;
      tmr_n   = '0;
    end else begin
      case (state)
        ST_IDLE: if (hi_valid) do_grant = 1'b1;
        ST_SFX: begin
          if (preempt) begin
            do_grant = 1'b1;
          end else if (tmr == 32'd1) begin
            tmr_n   = GAP_LEN;
            state_n = ST_GAP;
          end else begin
            tmr_n = tmr - 32'd1;
          end
        end
        ST_GAP: begin
          if (tmr == 32'd1) begin
            if (hi_valid) do_grant = 1'b1;
            else          state_n  = ST_IDLE;
          end else begin
            tmr_n = tmr - 32'd1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
      if (do_grant) begin
        grant    = 4'b0001 << hi_id;
        state_n  = ST_SFX;
        cur_id_n = hi_id;
        tmr_n    = (hi_id == 2'd3) ? GO_LEN : SFX_LEN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      tmr    <= '0;
      cur_id <= '0;
    end else begin
      state  <= state_n;
      tmr    <= tmr_n;
      cur_id <= cur_id_n;
    end
  end

  // Set beats clear: a new edge on the granted id re-arms it for a later replay.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_req   <= '0;
      pend       <= '0;
      drop_count <= '0;
    end else begin
      prev_req <= req;
      if (!sound_en) begin
        pend <= '0;
      end else begin
        pend <= (pend & ~grant) | req_edge;
        if (|(req_edge & pend) && drop_count != 8'd255)
          drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !sound_en) begin
      note_timer <= '0;
      note_idx   <= '0;
    end else if (note_timer == NOTE_LAST) begin
      note_timer <= '0;
      note_idx   <= note_idx + 2'd1;
    end else begin
      note_timer <= note_timer + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period    <= 32'd151745;
      pwm_en    <= 1'b0;
      busy      <= 1'b0;
      active_id <= '0;
    end else begin
      busy <= (state != ST_IDLE);
      case (state)
        ST_SFX: begin
          period    <= sfx_period(cur_id);
          pwm_en    <= 1'b1;
          active_id <= cur_id;
        end
        ST_GAP: begin
          pwm_en    <= 1'b0;
          active_id <= '0;
        end
        default: begin
          period    <= note_period(note_idx);
          pwm_en    <= sound_en;
          active_id <= '0;
        end
      endcase
    end
  end

  assign width = {1'b0, period[31:1]};

endmodule

// File: tb/tb_tetris_sound_sched.sv
// Directed self-checking bench for tetris_sound_sched (SFX=20, NOTE=50, GAP=4 clocks).
module tb_tetris_sound_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        sound_en;
  logic [3:0]  req;
  logic [31:0] period, width;
  logic        pwm_en, busy;
  logic [1:0]  active_id;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  tetris_sound_sched #(
    .SFX_TICKS (20),
    .NOTE_TICKS(50),
    .GAP_TICKS (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sound_en  (sound_en),
    .req       (req),
    .period    (period),
    .width     (width),
    .pwm_en    (pwm_en),
    .busy      (busy),
    .active_id (active_id),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_period"}, period, 151745);
    check_val({tag, "_width"}, width, 75872);
    check_val({tag, "_pwm_en"}, 32'(pwm_en), 0);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_active"}, 32'(active_id), 0);
    check_val({tag, "_drop"}, 32'(drop_count), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; sound_en = 1'b1; req = '0;
    tick(3);
    check_reset_state("reset");
    reset = 1'b0;

    // background loop, boundary at the 50-clock note wrap
    tick(25); check_val("note0", period, 151745); check_val("note0_en", 32'(pwm_en), 1);
    tick(25); check_val("note0_last", period, 151745);
    tick(1);  check_val("note1_first", period, 202479);
    tick(24); check_val("note1", period, 202479);
    tick(50); check_val("note2", period, 191113);
    tick(50); check_val("note3", period, 170262);
    tick(50); check_val("note_wrap", period, 151745);

    // single line-clear effect
    req = 4'b0010; tick(1); req = '0;
    tick(1); check_val("lc_lat_busy", 32'(busy), 0);
    tick(1);
    check_val("lc_period", period, 113636);
    check_val("lc_width", width, 56818);
    check_val("lc_active", 32'(active_id), 1);
    check_val("lc_busy", 32'(busy), 1);
    check_val("lc_en", 32'(pwm_en), 1);
    tick(19); check_val("lc_last_active", 32'(active_id), 1);
    tick(1);
    check_val("lc_gap_en", 32'(pwm_en), 0);
    check_val("lc_gap_busy", 32'(busy), 1);
    check_val("lc_gap_period", period, 113636);
    tick(3); check_val("lc_gap_end_en", 32'(pwm_en), 0);
    tick(1); check_val("lc_idle_busy", 32'(busy), 0); check_val("lc_idle_en", 32'(pwm_en), 1);

    // simultaneous game-over and lock: priority then queued
    req = 4'b1001; tick(1); req = '0;
    tick(2); check_val("go_active", 32'(active_id), 3); check_val("go_period", period, 606060);
    tick(39); check_val("go_last", 32'(active_id), 3);
    tick(1); check_val("go_gap_en", 32'(pwm_en), 0); check_val("go_gap_busy", 32'(busy), 1);
    tick(3); check_val("go_gap_end", 32'(pwm_en), 0);
    tick(1); check_val("lock_period", period, 454545); check_val("lock_en", 32'(pwm_en), 1);
    tick(19); check_val("lock_last", period, 454545);
    tick(1); check_val("lock_gap", 32'(pwm_en), 0);
    tick(4); check_val("lock_idle", 32'(busy), 0);

    // coalescing and saturation of drop_count
    req = 4'b0010; tick(1); req = '0;
    tick(2); check_val("co_active", 32'(active_id), 1);
    for (int i = 0; i < 3; i++) begin
      req = 4'b0001; tick(1); req = '0; tick(1);
    end
    check_val("co_drop2", 32'(drop_count), 2);
    tick(17); check_val("co_gap", 32'(pwm_en), 0);
    tick(1); check_val("co_lock_period", period, 454545); check_val("co_lock_busy", 32'(busy), 1);
    for (int i = 0; i < 300; i++) begin
      req = 4'b0001; tick(1); req = '0; tick(1);
    end
    check_val("co_drop_sat", 32'(drop_count), 255);
    tick(80); check_val("co_drain", 32'(busy), 0);

    // four-line clear arrives during cycle 5 of a lock effect
    req = 4'b0001; tick(1); req = '0;
    tick(1);
    tick(1); check_val("pr_id0", period, 454545);
    tick(2); req = 4'b0100;
    tick(1); req = '0;
    tick(1); check_val("pr_still0", period, 454545);
`ifdef TETRIS_SFX_PREEMPT_EN
    tick(1); check_val("pr_id2", period, 75757); check_val("pr_id2_active", 32'(active_id), 2);
    check_val("pr_nogap", 32'(pwm_en), 1);
    tick(19); check_val("pr_id2_last", period, 75757);
    tick(1); check_val("pr_gap", 32'(pwm_en), 0);
    tick(4); check_val("pr_idle", 32'(busy), 0);
`else
    tick(1); check_val("np_id0", period, 454545);
    tick(14); check_val("np_id0_last", period, 454545);
    tick(1); check_val("np_gap", 32'(pwm_en), 0);
    tick(4); check_val("np_id2", period, 75757); check_val("np_id2_active", 32'(active_id), 2);
    tick(19); check_val("np_id2_last", period, 75757);
    tick(1); check_val("np_gap2", 32'(pwm_en), 0);
    tick(4); check_val("np_idle", 32'(busy), 0);
`endif

    // sound_en dropped mid-effect with a pending lock
    req = 4'b0010; tick(1); req = '0;
    tick(2); check_val("se_active", 32'(active_id), 1);
    req = 4'b0001; tick(1); req = '0; tick(1);
    sound_en = 1'b0;
    tick(1); check_val("se_lag_en", 32'(pwm_en), 1);
    tick(1);
    check_val("se_off_en", 32'(pwm_en), 0);
    check_val("se_off_busy", 32'(busy), 0);
    check_val("se_off_active", 32'(active_id), 0);
    check_val("se_drop_held", 32'(drop_count), 255);
    tick(5);
    sound_en = 1'b1;
    tick(1); check_val("se_on_en", 32'(pwm_en), 1); check_val("se_on_note", period, 151745);
    tick(30); check_val("se_pend_lost", 32'(busy), 0); check_val("se_note_idx0", period, 151745);

    // reset asserted in the middle of an effect
    req = 4'b1000; tick(1); req = 4'b0001; tick(1); req = '0;
    tick(3); check_val("rs_active", 32'(active_id), 3);
    reset = 1'b1; tick(1);
    check_reset_state("rs_mid");
    reset = 1'b0;
    tick(40); check_val("rs_pend_lost", 32'(busy), 0); check_val("rs_note", period, 151745);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
